// File: rtl/xbar_addr_decode_fifo.sv
// +--------------------------------------------------------------------------+
// | xbar_addr_decode_fifo: address-channel FIFO that decodes the target       |
// | slave at push time. Rev 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module xbar_addr_decode_fifo #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3,
  parameter int slaves     = 2,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] address_map_base [0:slaves-1] = '{'h0000_0000, 'h1000_0000},
  parameter logic [ADDR_WIDTH-1:0] address_map_end  [0:slaves-1] = '{'h0fff_ffff, 'h1fff_ffff},
  localparam int DEST_W = (slaves > 1) ? $clog2(slaves) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ID_WIDTH-1:0]   AXID_M,
  input  logic [ADDR_WIDTH-1:0] AXADDR_M,
  input  logic [LEN_WIDTH-1:0]  AXLEN_M,
  input  logic [SIZE_WIDTH-1:0] AXSIZE_M,
  input  logic [1:0]            AXBURST_M,
  input  logic                  AXVALID_M,
  output logic                  AXREADY_M,
  output logic [ID_WIDTH-1:0]   AXID,
  output logic [ADDR_WIDTH-1:0] AXADDR,
  output logic [LEN_WIDTH-1:0]  AXLEN,
  output logic [SIZE_WIDTH-1:0] AXSIZE,
  output logic [1:0]            AXBURST,
  output logic                  fifo_empty,
  output logic [DEST_W-1:0]     forwarding_dest_slave,
  output logic                  decode_error,
  input  logic                  fifo_pop,
  output logic [CNT_W-1:0]      fifo_count
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2 + DEST_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic               full;
  logic               push;
  logic               pop;
  logic               dec_hit;
  logic [DEST_W-1:0]  dec_dest;
  logic [ENTRY_W-1:0] new_entry;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;

  assign wr_idx     = wr_ptr_q[IDX_W-1:0];
  assign rd_idx     = rd_ptr_q[IDX_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
  assign AXREADY_M  = !full;
  assign push       = AXVALID_M && !full;
  assign pop        = fifo_pop && !fifo_empty;
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  // Scan downwards so the lowest-numbered matching region is the final winner.
  always_comb begin
    dec_hit  = 1'b0;
    dec_dest = '0;
    for (int i = slaves - 1; i >= 0; i--) begin
      if ((AXADDR_M >= address_map_base[i]) && (AXADDR_M <= address_map_end[i])) begin
        dec_hit  = 1'b1;
        dec_dest = DEST_W'(i);
      end
    end
  end

  assign new_entry = {AXID_M, AXADDR_M, AXLEN_M, AXSIZE_M, AXBURST_M,
                      (dec_hit ? dec_dest : {DEST_W{1'b0}}), !dec_hit};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_idx] = new_entry;
      wr_ptr_d      = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is intentionally left out of reset; pointers alone define validity.
  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  assign {AXID, AXADDR, AXLEN, AXSIZE, AXBURST, forwarding_dest_slave, decode_error} = mem_q[rd_idx];

endmodule

`default_nettype wire
